// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline stall/flush bus between the stage request sources and pipe_stall_ctrl.
// The master side raises requests and consumes StallBus/flush; the slave side is the controller.
interface pipe_stall_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             stallreq_if;
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             stallreq_dt;
  logic             stallreq_dc;
  logic             stallreq_mem;
  logic             excp_valid;
  logic [31:0]      excp_pc;
  logic [7:0]       stall;
  logic             flush;
  logic [31:0]      flush_pc;
  logic             stall_timeout;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_dt, stallreq_dc, stallreq_mem,
    output excp_valid, excp_pc,
    input  stall, flush, flush_pc, stall_timeout, bubble_cnt
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_dt, stallreq_dc, stallreq_mem,
    input  excp_valid, excp_pc,
    output stall, flush, flush_pc, stall_timeout, bubble_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 8-stage pipeline: merges stage stall requests into
// StallBus, defers exception flushes past outstanding data-bus work, tracks watchdog and bubbles.
module pipe_stall_ctrl #(
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  pipe_stall_ctrl_if.slave  bus
);

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] FLUSH_WAIT = 2'd1;
  localparam logic [1:0] FLUSH      = 2'd2;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [7:0]           merged;
  logic [7:0]           stall_c;
  logic [31:0]          pc_q;
  logic [TIMEOUT_W-1:0] wd_q;
  logic                 timeout_q;
  logic [CNT_W-1:0]     bubble_q;
  logic                 bus_busy;

  assign bus_busy = bus.stallreq_dc | bus.stallreq_mem;

  // Deepest requesting stage stops itself and everything upstream of it.
  always_comb begin
    merged = '0;
    if      (bus.stallreq_mem) merged = 8'hFF;
    else if (bus.stallreq_dc)  merged = 8'h7F;
    else if (bus.stallreq_dt)  merged = 8'h3F;
    else if (bus.stallreq_ex)  merged = 8'h1F;
    else if (bus.stallreq_id)  merged = 8'h0F;
    else if (bus.stallreq_if)  merged = 8'h03;
  end

  always_comb begin
    stall_c   = '0;
    state_nxt = state;
    case (state)
      RUN: begin
        stall_c = merged;
        if (bus.excp_valid) state_nxt = bus_busy ? FLUSH_WAIT : FLUSH;
      end
      FLUSH_WAIT: begin
        stall_c = '1;
        if (!bus_busy) state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign bus.stall         = resetn ? stall_c : '0;
  assign bus.flush         = (state == FLUSH);
  assign bus.flush_pc      = pc_q;
  assign bus.stall_timeout = timeout_q;
  assign bus.bubble_cnt    = bubble_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
      pc_q  <= '0;
    end else begin
      state <= state_nxt;
      // Only RUN accepts an exception, so the first one owns the latch until the flush.
      if (state == RUN && bus.excp_valid) pc_q <= bus.excp_pc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (stall_c[0]) begin
      if (wd_q != '1) wd_q <= wd_q + TIMEOUT_W'(1);
      if (wd_q == '1 || wd_q + TIMEOUT_W'(1) == '1) timeout_q <= 1'b1;
    end else begin
      wd_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bubble_q <= '0;
    end else if (state != FLUSH && stall_c[3] && !stall_c[4]) begin
      bubble_q <= bubble_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: merge, load-use bubbles, clean and deferred flush,
// watchdog threshold and asynchronous reset during a deferred flush.
module tb_pipe_stall_ctrl;
  logic clk;
  logic resetn;
  int   errors;
  int   checks;

  pipe_stall_ctrl_if #(.CNT_W(32)) bus();

  pipe_stall_ctrl #(.TIMEOUT_W(4), .CNT_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.stallreq_if  = 1'b0;
    bus.stallreq_id  = 1'b0;
    bus.stallreq_ex  = 1'b0;
    bus.stallreq_dt  = 1'b0;
    bus.stallreq_dc  = 1'b0;
    bus.stallreq_mem = 1'b0;
    bus.excp_valid   = 1'b0;
    bus.excp_pc      = 32'h0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    @(posedge clk);
    #3;
    resetn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.stallreq_mem = 1'b1;
    resetn = 1'b0;
    #2;
    checks++;
    if (bus.stall !== 8'h00) begin errors++; $display("FAIL reset_stall got=%h exp=00", bus.stall); end
    checks++;
    if (bus.flush !== 1'b0 || bus.flush_pc !== 32'h0) begin
      errors++; $display("FAIL reset_flush got=%b/%h exp=0/00000000", bus.flush, bus.flush_pc);
    end
    checks++;
    if (bus.stall_timeout !== 1'b0 || bus.bubble_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_counters got=%b/%0d exp=0/0", bus.stall_timeout, bus.bubble_cnt);
    end
    do_reset();
  endtask

  task automatic test_merge();
    logic [7:0] exp_tab [7];
    logic [5:0] req_tab [7];
    // req bits: {mem, dc, dt, ex, id, if}
    req_tab = '{6'b000010, 6'b000110, 6'b100110, 6'b000000, 6'b000001, 6'b001000, 6'b010000};
    exp_tab = '{8'h0F,     8'h1F,     8'hFF,     8'h00,     8'h03,     8'h3F,     8'h7F};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      {bus.stallreq_mem, bus.stallreq_dc, bus.stallreq_dt,
       bus.stallreq_ex, bus.stallreq_id, bus.stallreq_if} = req_tab[i];
      #1;
      checks++;
      if (bus.stall !== exp_tab[i]) begin
        errors++; $display("FAIL merge_%0d got=%h exp=%h", i, bus.stall, exp_tab[i]);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    bus.stallreq_id = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (bus.stall !== 8'h0F || bus.flush !== 1'b0) begin
        errors++; $display("FAIL load_use_stall_%0d got=%h/%b exp=0f/0", i, bus.stall, bus.flush);
      end
      step();
    end
    bus.stallreq_id = 1'b0;
    #1;
    checks++;
    if (bus.bubble_cnt !== 32'd2 || bus.stall !== 8'h00) begin
      errors++; $display("FAIL load_use_bubbles got=%0d/%h exp=2/00", bus.bubble_cnt, bus.stall);
    end
    step();
    checks++;
    if (bus.bubble_cnt !== 32'd2 || bus.flush !== 1'b0) begin
      errors++; $display("FAIL load_use_hold got=%0d/%b exp=2/0", bus.bubble_cnt, bus.flush);
    end
  endtask

  task automatic test_clean_exception();
    do_reset();
    bus.excp_valid = 1'b1;
    bus.excp_pc    = 32'hBFC00380;
    #1;
    checks++;
    if (bus.stall !== 8'h00 || bus.flush !== 1'b0) begin
      errors++; $display("FAIL clean_same_cycle got=%h/%b exp=00/0", bus.stall, bus.flush);
    end
    step();
    clear_inputs();
    #1;
    checks++;
    if (bus.flush !== 1'b1 || bus.flush_pc !== 32'hBFC00380 || bus.stall !== 8'h00) begin
      errors++; $display("FAIL clean_flush got=%b/%h/%h exp=1/bfc00380/00", bus.flush, bus.flush_pc, bus.stall);
    end
    step();
    checks++;
    if (bus.flush !== 1'b0) begin errors++; $display("FAIL clean_flush_end got=%b exp=0", bus.flush); end
  endtask

  task automatic test_deferred_flush();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      bus.stallreq_dc = (c < 5);
      bus.excp_valid  = (c == 0 || c == 2);
      bus.excp_pc     = (c == 0) ? 32'hBFC00380 : 32'h0;
      #1;
      checks++;
      if (c == 0) begin
        if (bus.stall !== 8'h7F || bus.flush !== 1'b0) begin
          errors++; $display("FAIL deferred_c0 got=%h/%b exp=7f/0", bus.stall, bus.flush);
        end
      end else if (c <= 5) begin
        if (bus.stall !== 8'hFF || bus.flush !== 1'b0) begin
          errors++; $display("FAIL deferred_wait_c%0d got=%h/%b exp=ff/0", c, bus.stall, bus.flush);
        end
      end else if (c == 6) begin
        if (bus.flush !== 1'b1 || bus.flush_pc !== 32'hBFC00380 || bus.stall !== 8'h00) begin
          errors++; $display("FAIL deferred_flush got=%b/%h/%h exp=1/bfc00380/00", bus.flush, bus.flush_pc, bus.stall);
        end
      end else begin
        if (bus.flush !== 1'b0 || bus.stall !== 8'h00) begin
          errors++; $display("FAIL deferred_after got=%b/%h exp=0/00", bus.flush, bus.stall);
        end
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_watchdog();
    do_reset();
    bus.stallreq_if = 1'b1;
    repeat (14) step();
    checks++;
    if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL wd_at14 got=%b exp=0", bus.stall_timeout); end
    step();
    checks++;
    if (bus.stall_timeout !== 1'b1) begin errors++; $display("FAIL wd_at15 got=%b exp=1", bus.stall_timeout); end
    bus.stallreq_if = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.stall_timeout !== 1'b1) begin errors++; $display("FAIL wd_sticky got=%b exp=1", bus.stall_timeout); end

    do_reset();
    for (int r = 0; r < 2; r++) begin
      bus.stallreq_if = 1'b1;
      repeat (14) step();
      bus.stallreq_if = 1'b0;
      step();
    end
    checks++;
    if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL wd_14_clear got=%b exp=0", bus.stall_timeout); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    bus.stallreq_id = 1'b1;
    step();
    bus.stallreq_id = 1'b0;
    bus.stallreq_dc = 1'b1;
    bus.excp_valid  = 1'b1;
    bus.excp_pc     = 32'h8000_0180;
    step();
    bus.excp_valid = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 8'hFF || bus.bubble_cnt !== 32'd1) begin
      errors++; $display("FAIL rst_wait_pre got=%h/%0d exp=ff/1", bus.stall, bus.bubble_cnt);
    end
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.flush !== 1'b0 || bus.stall !== 8'h00 || bus.bubble_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_wait_async got=%b/%h/%0d exp=0/00/0", bus.flush, bus.stall, bus.bubble_cnt);
    end
    clear_inputs();
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.flush !== 1'b0 || bus.stall !== 8'h00 || bus.flush_pc !== 32'h0) begin
        errors++; $display("FAIL rst_wait_post_%0d got=%b/%h/%h exp=0/00/00000000", i, bus.flush, bus.stall, bus.flush_pc);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clear_inputs();
    resetn = 1'b0;
    test_reset();
    test_merge();
    test_load_use();
    test_clean_exception();
    test_deferred_flush();
    test_watchdog();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
